// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

endpackage

// File: rtl/prescale_tick.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles; clear restarts the phase.
module prescale_tick #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_pass
         logic unused_ok;
         assign unused_ok = clk ^ rst_n ^ clear;
         assign tick      = enable;
      end else begin : g_div
         localparam int unsigned W = $clog2(PRESCALE);
         localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

         logic [W-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
            end else if (clear) begin
               cnt <= '0;
            end else if (enable) begin
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
         end

         assign tick = enable && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled ticks, pause, abort, optional auto-reload
// and a valid/ready expiry event.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned N        = 32,
   parameter int unsigned PRESCALE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] load_value,
   input  logic         reload_en,
   input  logic         enable,
   input  logic         abort,
   output logic         exp_valid,
   input  logic         exp_ready,
   output logic [N-1:0] count,
   output logic         busy
);

   timer_state_t state, state_next;
   logic [N-1:0] count_next;
   logic [N-1:0] reload, reload_next;
   logic         clear;
   logic         tick_en;
   logic         tick;

   // Prescaler only advances while counting; its clear comes from the FSM.
   assign tick_en = (state == RUN) && enable;

   prescale_tick #(
      .PRESCALE (PRESCALE)
   ) u_prescale (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .enable (tick_en),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         reload <= reload_next;
      end
   end

   always_comb begin
      state_next  = state;
      count_next  = count;
      reload_next = reload;
      clear       = 1'b0;

      if (abort) begin
         state_next = IDLE;
         count_next = '0;
         clear      = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_valid) begin
                  count_next  = load_value;
                  reload_next = load_value;
                  clear       = 1'b1;
                  state_next  = (load_value == '0) ? EXPIRED : RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  // Saturating: a tick at 1 (or 0) lands on zero and expires.
                  if (count <= N'(1)) begin
                     count_next = '0;
                     state_next = EXPIRED;
                  end else begin
                     count_next = count - 1'b1;
                  end
               end
            end
            EXPIRED: begin
               count_next = '0;
               if (exp_ready) begin
                  if (reload_en && (reload != '0)) begin
                     count_next = reload;
                     clear      = 1'b1;
                     state_next = RUN;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
               clear      = 1'b1;
            end
         endcase
      end
   end

   assign load_ready = (state == IDLE);
   assign exp_valid  = (state == EXPIRED);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: a PRESCALE=1 and a PRESCALE=4 instance share the same stimulus.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_value = '0;
   logic       reload_en = 1'b0;
   logic       enable = 1'b0;
   logic       abort = 1'b0;
   logic       exp_ready = 1'b0;

   logic       ready1, expv1, busy1;
   logic [7:0] count1;
   logic       ready4, expv4, busy4;
   logic [7:0] count4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   countdown_timer #(.N(8), .PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready1),
      .load_value(load_value), .reload_en(reload_en), .enable(enable), .abort(abort),
      .exp_valid(expv1), .exp_ready(exp_ready), .count(count1), .busy(busy1)
   );

   countdown_timer #(.N(8), .PRESCALE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready4),
      .load_value(load_value), .reload_en(reload_en), .enable(enable), .abort(abort),
      .exp_valid(expv4), .exp_ready(exp_ready), .count(count4), .busy(busy4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load_valid = 1'b1;
      load_value = v;
      step();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (count1 !== 8'd0) begin errors++; $display("FAIL reset_count1 got=%0d exp=0", count1); end
      checks++; if ({ready1, expv1, busy1} !== 3'b100) begin errors++; $display("FAIL reset_flags1 got=%b exp=100", {ready1, expv1, busy1}); end
      checks++; if ({ready4, expv4, busy4, count4} !== {3'b100, 8'd0}) begin errors++; $display("FAIL reset_dut4 got=%b exp=10000000000", {ready4, expv4, busy4, count4}); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      do_abort();
      enable = 1'b1; exp_ready = 1'b1; reload_en = 1'b0;
      do_load(8'd5);
      checks++; if (count1 !== 8'd5 || busy1 !== 1'b1) begin errors++; $display("FAIL basic_load got=%0d/%b exp=5/1", count1, busy1); end
      for (int i = 4; i >= 1; i--) begin
         step();
         checks++; if (count1 !== 8'(i) || expv1 !== 1'b0) begin errors++; $display("FAIL basic_count got=%0d/%b exp=%0d/0", count1, expv1, i); end
      end
      step();
      checks++; if (count1 !== 8'd0 || expv1 !== 1'b1) begin errors++; $display("FAIL basic_expire got=%0d/%b exp=0/1", count1, expv1); end
      step();
      checks++; if ({ready1, expv1, busy1} !== 3'b100) begin errors++; $display("FAIL basic_idle got=%b exp=100", {ready1, expv1, busy1}); end
   endtask

   task automatic test_prescale();
      do_abort();
      enable = 1'b1; exp_ready = 1'b1; reload_en = 1'b0;
      do_load(8'd3);
      checks++; if (count4 !== 8'd3) begin errors++; $display("FAIL pre_load got=%0d exp=3", count4); end
      for (int j = 1; j <= 12; j++) begin
         step();
         checks++;
         if (count4 !== 8'(3 - j / 4) || expv4 !== (j == 12)) begin
            errors++; $display("FAIL pre_cycle%0d got=%0d/%b exp=%0d/%b", j, count4, expv4, 3 - j / 4, (j == 12));
         end
      end
   endtask

   task automatic test_pause();
      do_abort();
      enable = 1'b1; exp_ready = 1'b1; reload_en = 1'b0;
      do_load(8'd6);
      step(); step();
      checks++; if (count1 !== 8'd4) begin errors++; $display("FAIL pause_pre got=%0d exp=4", count1); end
      enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         checks++; if (count1 !== 8'd4 || busy1 !== 1'b1) begin errors++; $display("FAIL pause_hold got=%0d/%b exp=4/1", count1, busy1); end
      end
      enable = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         step();
         checks++; if (count1 !== 8'(i) || expv1 !== 1'b0) begin errors++; $display("FAIL pause_resume got=%0d exp=%0d", count1, i); end
      end
      step();
      checks++; if (expv1 !== 1'b1 || count1 !== 8'd0) begin errors++; $display("FAIL pause_expire got=%b/%0d exp=1/0", expv1, count1); end
   endtask

   task automatic test_hold_reload();
      do_abort();
      enable = 1'b1; exp_ready = 1'b0; reload_en = 1'b1;
      do_load(8'd2);
      step(); step();
      checks++; if (expv1 !== 1'b1) begin errors++; $display("FAIL hold_expire got=%b exp=1", expv1); end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (expv1 !== 1'b1 || count1 !== 8'd0) begin errors++; $display("FAIL hold_wait got=%b/%0d exp=1/0", expv1, count1); end
      end
      exp_ready = 1'b1;
      step();
      checks++; if (count1 !== 8'd2 || expv1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL reload_restart got=%0d/%b/%b exp=2/0/1", count1, expv1, busy1); end
      step();
      checks++; if (count1 !== 8'd1 || expv1 !== 1'b0) begin errors++; $display("FAIL reload_count got=%0d/%b exp=1/0", count1, expv1); end
      step();
      checks++; if (count1 !== 8'd0 || expv1 !== 1'b1) begin errors++; $display("FAIL reload_expire got=%0d/%b exp=0/1", count1, expv1); end
      reload_en = 1'b0;
      step();
      checks++; if ({ready1, expv1, busy1} !== 3'b100) begin errors++; $display("FAIL reload_idle got=%b exp=100", {ready1, expv1, busy1}); end
   endtask

   task automatic test_boundary();
      do_abort();
      enable = 1'b1; exp_ready = 1'b0; reload_en = 1'b1;
      do_load(8'd0);
      checks++; if (expv1 !== 1'b1 || ready1 !== 1'b0 || count1 !== 8'd0) begin errors++; $display("FAIL zero_load got=%b/%b/%0d exp=1/0/0", expv1, ready1, count1); end
      exp_ready = 1'b1;
      step();
      checks++; if ({ready1, expv1, busy1} !== 3'b100) begin errors++; $display("FAIL zero_noreload got=%b exp=100", {ready1, expv1, busy1}); end
      reload_en = 1'b0;
      do_load(8'd255);
      checks++; if (count1 !== 8'd255 || ready1 !== 1'b0) begin errors++; $display("FAIL max_load got=%0d/%b exp=255/0", count1, ready1); end
      load_valid = 1'b1; load_value = 8'd7;
      step();
      load_valid = 1'b0;
      checks++; if (count1 !== 8'd254 || ready1 !== 1'b0) begin errors++; $display("FAIL load_in_run got=%0d/%b exp=254/0", count1, ready1); end
      for (int j = 2; j <= 254; j++) step();
      checks++; if (count1 !== 8'd1 || expv1 !== 1'b0) begin errors++; $display("FAIL max_penult got=%0d/%b exp=1/0", count1, expv1); end
      step();
      checks++; if (count1 !== 8'd0 || expv1 !== 1'b1) begin errors++; $display("FAIL max_expire got=%0d/%b exp=0/1", count1, expv1); end
   endtask

   task automatic test_abort();
      do_abort();
      enable = 1'b1; exp_ready = 1'b0; reload_en = 1'b1;
      do_load(8'd3);
      step(); step(); step();
      checks++; if (expv1 !== 1'b1) begin errors++; $display("FAIL abort_setup got=%b exp=1", expv1); end
      exp_ready = 1'b1; abort = 1'b1;
      step();
      abort = 1'b0; exp_ready = 1'b0;
      checks++; if ({ready1, expv1, busy1} !== 3'b100 || count1 !== 8'd0) begin errors++; $display("FAIL abort_vs_ready got=%b/%0d exp=100/0", {ready1, expv1, busy1}, count1); end
      do_load(8'd2);
      step();
      checks++; if (count1 !== 8'd1) begin errors++; $display("FAIL abort_tick_setup got=%0d exp=1", count1); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if ({ready1, expv1, busy1} !== 3'b100 || count1 !== 8'd0) begin errors++; $display("FAIL abort_vs_tick got=%b/%0d exp=100/0", {ready1, expv1, busy1}, count1); end
      step();
      checks++; if (expv1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL abort_no_event got=%b/%b exp=0/0", expv1, busy1); end
   endtask

   task automatic test_async_reset();
      do_abort();
      enable = 1'b1; exp_ready = 1'b1; reload_en = 1'b0;
      do_load(8'd9);
      step();
      checks++; if (count1 !== 8'd8) begin errors++; $display("FAIL rst_setup got=%0d exp=8", count1); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({ready1, expv1, busy1, count1} !== {3'b100, 8'd0}) begin errors++; $display("FAIL rst_async1 got=%b/%0d exp=100/0", {ready1, expv1, busy1}, count1); end
      checks++; if ({ready4, expv4, busy4, count4} !== {3'b100, 8'd0}) begin errors++; $display("FAIL rst_async4 got=%b/%0d exp=100/0", {ready4, expv4, busy4}, count4); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (busy1 !== 1'b0 || count1 !== 8'd0) begin errors++; $display("FAIL rst_after got=%b/%0d exp=0/0", busy1, count1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prescale();
      test_pause();
      test_hold_reload();
      test_boundary();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
